// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the uart_tx arbiter slice
//   BYTE_W           serial byte width
//   DEF_LOCK_TIMEOUT default idle clocks a frame owner may hold the lock
//   arb_state_t      arbiter FSM states
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int DEF_LOCK_TIMEOUT = 65535;
    typedef enum logic [2:0] {SYNC, IDLE, LOAD, WAIT_DONE, GAP, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr wins
//   req   request vector
//   ptr   highest-priority index this cycle
//   gnt   one-hot grant (zero when nothing requests)
//   found some request was granted
module rr_pick #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          found
);
    always_comb begin
        gnt = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte clients with frame locking
//   clock, i_rst_n                  clock, async active-low reset
//   i_req_valid/_byte/_last         per-client byte offer (byte n on [8n+7:8n])
//   o_req_ready                     one-hot accept strobe, byte taken on valid&ready
//   o_tx_data_avail/o_tx_data_byte  start pulse and held byte towards uart_tx
//   i_tx_active, i_tx_done          uart_tx busy level and completion pulse
//   o_grant, o_locked, o_lock_abort current/last owner, frame lock, lock timeout pulse
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] i_req_byte,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_tx_data_avail,
    output logic [BYTE_W-1:0]         o_tx_data_byte,
    input  logic                      i_tx_active,
    input  logic                      i_tx_done,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_locked,
    output logic                      o_lock_abort
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t state;
    logic [PW-1:0] ptr, owner, sel, nxt;
    logic [CW-1:0] cnt;
    logic last_q, found;
    logic [NUM_REQ-1:0] pick;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req  (i_req_valid),
        .ptr  (ptr),
        .gnt  (pick),
        .found(found)
    );

    // index of the client being accepted: the round-robin winner in IDLE, else the lock owner
    always_comb begin
        sel = owner;
        if (state == IDLE)
            for (int i = 0; i < NUM_REQ; i++)
                if (pick[i]) sel = PW'(i);
    end

    assign nxt = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    assign o_req_ready = (state == IDLE && found) ? pick :
                         (state == LOCKED && i_req_valid[owner]) ? (NUM_REQ'(1) << owner) : '0;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SYNC;
            ptr <= '0;
            owner <= '0;
            cnt <= '0;
            last_q <= 1'b0;
            o_tx_data_avail <= 1'b0;
            o_tx_data_byte <= '0;
            o_grant <= '0;
            o_locked <= 1'b0;
            o_lock_abort <= 1'b0;
        end else begin
            o_tx_data_avail <= 1'b0;
            o_lock_abort <= 1'b0;
            case (state)
                // the serializer is not reset with us, so let any byte in flight drain
                SYNC: if (!i_tx_active) state <= IDLE;
                IDLE, LOCKED: begin
                    if (|o_req_ready) begin
                        owner <= sel;
                        o_tx_data_byte <= i_req_byte[sel*BYTE_W +: BYTE_W];
                        last_q <= i_req_last[sel];
                        o_grant <= o_req_ready;
                        o_tx_data_avail <= 1'b1;
                        state <= LOAD;
                    end else if (state == LOCKED) begin
                        if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                            o_lock_abort <= 1'b1;
                            o_locked <= 1'b0;
                            ptr <= nxt;
                            state <= IDLE;
                        end else if (cnt != {CW{1'b1}}) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD: state <= WAIT_DONE;
                WAIT_DONE: if (i_tx_done) state <= GAP;
                // one idle cycle lets uart_tx finish its cleanup before the next start
                GAP: begin
                    if (last_q) begin
                        o_locked <= 1'b0;
                        ptr <= nxt;
                        state <= IDLE;
                    end else begin
                        o_locked <= 1'b1;
                        cnt <= '0;
                        state <= LOCKED;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scenario bench with a rule-level arbitration model and uart_tx stand-in
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last = '0;
    logic [8*N-1:0] req_byte = '0;
    logic [N-1:0] req_ready, grant;
    logic tx_avail, locked, lock_abort;
    logic [7:0] tx_byte;
    logic tx_active = 1'b0;
    logic tx_done = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
        .clock          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .i_req_byte     (req_byte),
        .i_req_last     (req_last),
        .o_req_ready    (req_ready),
        .o_tx_data_avail(tx_avail),
        .o_tx_data_byte (tx_byte),
        .i_tx_active    (tx_active),
        .i_tx_done      (tx_done),
        .o_grant        (grant),
        .o_locked       (locked),
        .o_lock_abort   (lock_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cl;
        logic [7:0] b;
        int c;
        logic [N-1:0] g;
    } ev_t;

    ev_t exp_q[$];
    ev_t acc_log[$];
    ev_t line_log[$];
    logic [8:0] cq[N][$];

    int errors = 0, checks = 0, cyc = 0;
    int last_done = -100, tx_cnt = 0;
    int ptr_m = 0, owner_m = 0;
    int abort_n = 0, abort_cyc = -1, lock_rise = -1;
    bit in_frame = 0, hold = 0, rand_gate = 0, locked_prev = 0, done_real = 0, abort_locked = 0;

    function automatic int first_from(int p, logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int n = 0; n < N; n++)
            if (cq[n].size() != 0) return 0;
        return 1;
    endfunction

    task automatic drive();
        logic [8:0] h;
        for (int n = 0; n < N; n++) begin
            h = (cq[n].size() > 0) ? cq[n][0] : {1'b0, 8'($urandom)};
            req_valid[n] = (cq[n].size() > 0) && (!rand_gate || $urandom_range(0, 3) != 0);
            req_byte[n*8 +: 8] = h[7:0];
            req_last[n] = h[8];
        end
    endtask

    task automatic mreset();
        exp_q.delete();
        in_frame = 0;
        ptr_m = 0;
        abort_n = 0;
        abort_cyc = -1;
        lock_rise = -1;
        locked_prev = 0;
    endtask

    // observe the settled cycle, then advance one clock and update uart_tx stand-in and clients
    task automatic cycle();
        int cl, w;
        bit start;
        logic [8:0] h;
        ev_t e;
        checks++;
        if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
            errors++;
            $display("FAIL ready_shape: cycle %0d ready=%b valid=%b required one-hot subset of valid", cyc, req_ready, req_valid);
        end
        if (lock_abort) begin
            checks++;
            if (!in_frame) begin
                errors++;
                $display("FAIL abort_unexpected: cycle %0d abort=1 required 0 with no frame open", cyc);
            end
            abort_n++;
            abort_cyc = cyc;
            abort_locked = locked;
            in_frame = 0;
            ptr_m = (owner_m + 1) % N;
        end
        if (locked && !locked_prev) lock_rise = cyc;
        locked_prev = locked;
        if (tx_avail) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL avail_unexpected: cycle %0d avail=1 byte=%h required no pulse", cyc, tx_byte);
            end else begin
                e = exp_q.pop_front();
                if (tx_byte !== e.b || cyc != e.c + 1 || grant !== (N'(1) << e.cl)) begin
                    errors++;
                    $display("FAIL avail: cycle %0d byte=%h grant=%b required cycle %0d byte=%h client %0d", cyc, tx_byte, grant, e.c + 1, e.b, e.cl);
                end
            end
            line_log.push_back('{idx_of(grant), tx_byte, cyc, grant});
        end
        if ((req_ready & req_valid) != '0) begin
            cl = idx_of(req_ready & req_valid);
            w = in_frame ? owner_m : first_from(ptr_m, req_valid);
            checks++;
            if (cl != w) begin
                errors++;
                $display("FAIL winner: cycle %0d accepted client %0d required %0d", cyc, cl, w);
            end
            checks++;
            if (cyc < last_done + 2) begin
                errors++;
                $display("FAIL done_gap: accept at cycle %0d required >= %0d", cyc, last_done + 2);
            end
            h = {req_last[cl], req_byte[cl*8 +: 8]};
            exp_q.push_back('{cl, h[7:0], cyc, '0});
            acc_log.push_back('{cl, h[7:0], cyc, '0});
            if (h[8]) begin
                in_frame = 0;
                ptr_m = (cl + 1) % N;
            end else begin
                in_frame = 1;
                owner_m = cl;
            end
            if (cq[cl].size() > 0) void'(cq[cl].pop_front());
        end
        if (done_real) last_done = cyc;
        start = tx_avail;
        @(posedge clk);
        #1;
        cyc++;
        tx_done = 1'b0;
        done_real = 0;
        if (hold) tx_active = 1'b1;
        else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_active = 1'b0;
                tx_done = 1'b1;
                done_real = 1;
            end
        end
        if (start) begin
            tx_active = 1'b1;
            tx_cnt = $urandom_range(3, 8);
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mreset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic run_idle(int budget);
        int n = 0;
        while (n < budget && !(all_empty() && exp_q.size() == 0 && !tx_active && !tx_done)) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        int a0, l0, n;
        #1;
        checks++;
        if ({tx_avail, tx_byte, grant, locked, lock_abort, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: avail=%b byte=%h grant=%b locked=%b abort=%b ready=%b required all 0", tx_avail, tx_byte, grant, locked, lock_abort, req_ready);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        cq[2].push_back(9'h120);
        run_idle(200);
        cq[1].push_back(9'h121);
        l0 = line_log.size();
        n = 0;
        while (line_log.size() == l0 && n < 100) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        hold = 1;
        rst_n = 1'b0;
        #1;
        mreset();
        checks++;
        if ({tx_avail, tx_byte, grant, locked, lock_abort, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_midbyte: avail=%b byte=%h grant=%b locked=%b abort=%b ready=%b required all 0", tx_avail, tx_byte, grant, locked, lock_abort, req_ready);
        end
        cq[1].push_back(9'h122);
        cq[3].push_back(9'h133);
        a0 = acc_log.size();
        l0 = line_log.size();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (6) cycle();
        checks++;
        if (acc_log.size() != a0 || line_log.size() != l0) begin
            errors++;
            $display("FAIL sync_hold: accepts=%0d lines=%0d while serializer busy, required 0 and 0", acc_log.size() - a0, line_log.size() - l0);
        end
        hold = 0;
        tx_active = 1'b0;
        tx_cnt = 0;
        run_idle(300);
        checks++;
        if (acc_log.size() < a0 + 2 || acc_log[a0].cl != 1 || acc_log[a0 + 1].cl != 3) begin
            errors++;
            $display("FAIL reset_ptr: accepts=%0d first client %0d required 2 accepts, clients 1 then 3", acc_log.size() - a0, acc_log[a0].cl);
        end
    endtask

    task automatic test_single();
        int a0, l0;
        do_reset();
        a0 = acc_log.size();
        l0 = line_log.size();
        cq[2].push_back(9'h141);
        cq[2].push_back(9'h142);
        run_idle(300);
        checks++;
        if (acc_log.size() < a0 + 2 || acc_log[a0].cl != 2 || line_log[l0].b !== 8'h41 || line_log[l0].c != acc_log[a0].c + 1 || line_log[l0].g !== 4'b0100) begin
            errors++;
            $display("FAIL single: client %0d byte=%h grant=%b avail cycle %0d required client 2 byte=41 grant=0100 cycle %0d", acc_log[a0].cl, line_log[l0].b, line_log[l0].g, line_log[l0].c, acc_log[a0].c + 1);
        end
    endtask

    task automatic test_all4();
        int l0;
        do_reset();
        l0 = line_log.size();
        for (int r = 0; r < 2; r++)
            for (int n = 0; n < N; n++)
                cq[n].push_back(9'h110 + 9'(n));
        run_idle(600);
        checks++;
        if (line_log.size() != l0 + 2 * N) begin
            errors++;
            $display("FAIL all4_count: %0d bytes on line required %0d", line_log.size() - l0, 2 * N);
        end else begin
            for (int i = 0; i < 2 * N; i++) begin
                checks++;
                if (line_log[l0 + i].cl != i % N || line_log[l0 + i].b !== 8'(8'h10 + i % N)) begin
                    errors++;
                    $display("FAIL all4_order: slot %0d client %0d byte=%h required client %0d byte=%h", i, line_log[l0 + i].cl, line_log[l0 + i].b, i % N, 8'(8'h10 + i % N));
                end
            end
        end
    endtask

    task automatic test_frame();
        int l0;
        logic [7:0] eb[4];
        int ec[4];
        eb = '{8'hAA, 8'hBB, 8'hCC, 8'h33};
        ec = '{1, 1, 1, 3};
        do_reset();
        l0 = line_log.size();
        cq[1].push_back(9'h0AA);
        cq[1].push_back(9'h0BB);
        cq[1].push_back(9'h1CC);
        cq[3].push_back(9'h133);
        run_idle(400);
        checks++;
        if (line_log.size() != l0 + 4) begin
            errors++;
            $display("FAIL frame_count: %0d bytes on line required 4", line_log.size() - l0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (line_log[l0 + i].b !== eb[i] || line_log[l0 + i].cl != ec[i]) begin
                    errors++;
                    $display("FAIL frame_order: slot %0d byte=%h client %0d required byte=%h client %0d", i, line_log[l0 + i].b, line_log[l0 + i].cl, eb[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int a0, n;
        do_reset();
        cq[0].push_back(9'h055);
        n = 0;
        while (lock_rise < 0 && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (lock_rise < 0) begin
            errors++;
            $display("FAIL lock_entry: o_locked never rose, required rise after last=0 byte");
        end
        a0 = acc_log.size();
        cq[2].push_back(9'h177);
        n = 0;
        while (acc_log.size() == a0 && n < 100) begin
            cycle();
            n++;
        end
        run_idle(300);
        checks++;
        if (abort_n != 1 || abort_cyc != lock_rise + TO || abort_locked) begin
            errors++;
            $display("FAIL lock_abort: pulses=%0d at cycle %0d locked=%b required 1 pulse at cycle %0d locked=0", abort_n, abort_cyc, abort_locked, lock_rise + TO);
        end
        checks++;
        if (acc_log.size() <= a0 || acc_log[a0].cl != 2 || acc_log[a0].c < abort_cyc) begin
            errors++;
            $display("FAIL after_abort: client %0d at cycle %0d required client 2 at or after cycle %0d", acc_log[a0].cl, acc_log[a0].c, abort_cyc);
        end
    endtask

    task automatic test_spurious();
        int a0, l0;
        logic [N-1:0] g;
        do_reset();
        repeat (3) cycle();
        g = grant;
        a0 = acc_log.size();
        l0 = line_log.size();
        tx_done = 1'b1;
        repeat (4) cycle();
        checks++;
        if (acc_log.size() != a0 || line_log.size() != l0 || locked !== 1'b0 || grant !== g || tx_avail !== 1'b0) begin
            errors++;
            $display("FAIL spurious_done: accepts=%0d lines=%0d locked=%b grant=%b required 0 0 0 %b", acc_log.size() - a0, line_log.size() - l0, locked, grant, g);
        end
        cq[0].push_back(9'h1A5);
        run_idle(200);
        checks++;
        if (line_log.size() != l0 + 1 || line_log[l0].b !== 8'hA5 || line_log[l0].cl != 0) begin
            errors++;
            $display("FAIL spurious_recover: lines=%0d byte=%h required 1 line byte=a5 client 0", line_log.size() - l0, line_log[l0].b);
        end
    endtask

    task automatic test_random();
        int l0, c, len;
        logic [7:0] b;
        logic [7:0] expb[N][$];
        do_reset();
        rand_gate = 1;
        l0 = line_log.size();
        for (int f = 0; f < 40; f++) begin
            c = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                cq[c].push_back({k == len - 1, b});
                expb[c].push_back(b);
            end
        end
        run_idle(20000);
        rand_gate = 0;
        for (int i = l0; i < line_log.size(); i++) begin
            c = line_log[i].cl;
            checks++;
            if (c < 0 || expb[c].size() == 0 || line_log[i].b !== expb[c][0]) begin
                errors++;
                $display("FAIL random_stream: line %0d client %0d byte=%h required next byte of that client", i - l0, c, line_log[i].b);
            end else begin
                void'(expb[c].pop_front());
            end
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (expb[n].size() != 0) begin
                errors++;
                $display("FAIL random_lost: client %0d has %0d bytes unsent required 0", n, expb[n].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_frame();
        test_timeout();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte sources, using round-robin arbitration with optional multi-byte frame locking.
- Sits between the application clients and the uart_tx instance. Drives that instance's i_data_avail/i_data_byte and consumes its o_active/o_done.
- Serializes client bytes so no byte is issued while a transmission is in flight. A stalled frame owner cannot hold the line indefinitely.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 65535, clocks a frame owner may idle between bytes before its lock is dropped.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-client byte valid.
- i_req_byte  input  8*NUM_REQ  client n byte on [8n+7:8n].
- i_req_last  input  NUM_REQ  byte is the last of its frame; 0 keeps the lock.
- o_req_ready  output  NUM_REQ  one-hot accept strobe; byte is taken when valid&ready.
- o_tx_data_avail  output  1  one-cycle start pulse to uart_tx.
- o_tx_data_byte  output  8  byte to uart_tx; held stable from pulse until done.
- i_tx_active  input  1  uart_tx busy.
- i_tx_done  input  1  uart_tx one-cycle completion pulse.
- o_grant  output  NUM_REQ  one-hot current/last owner.
- o_locked  output  1  frame lock held.
- o_lock_abort  output  1  one-cycle pulse when a lock times out.

Behaviour:
- Reset, asynchronous, values:
  - all outputs 0
  - rr pointer 0
  - byte register 0x00
  - state SYNC
- States:
  - SYNC: wait until i_tx_active=0, then IDLE. The serializer has no reset, so a reset mid-byte must let it drain.
  - IDLE:
    - Winner = first valid client searching ptr, ptr+1, ... mod NUM_REQ.
    - Assert o_req_ready[winner] combinationally this cycle.
    - Latch byte, last and owner. Set o_grant. Go to LOAD.
    - No valid client: stay in IDLE.
  - LOAD: o_tx_data_avail=1 for exactly one cycle, then WAIT_DONE.
  - WAIT_DONE: hold until i_tx_done=1, then GAP.
  - GAP: one idle cycle; uart_tx needs its cleanup cycle.
    - latched last=1: clear lock, ptr = owner+1 mod NUM_REQ, go to IDLE.
    - last=0: set o_locked, clear the timeout counter, go to LOCKED.
  - LOCKED:
    - Only the owner is eligible. If i_req_valid[owner]=1, assert its ready, latch, go to LOAD.
    - Other clients are never readied.
    - Counter increments each idle cycle. When it reaches LOCK_TIMEOUT-1: pulse o_lock_abort, clear o_locked, ptr = owner+1, go to IDLE.
- Latency:
  - Accept cycle N → o_tx_data_avail at N+1.
  - i_tx_done at cycle M → next accept no earlier than M+2.
- o_req_ready is never asserted outside IDLE/LOCKED and is never multi-hot.
- i_tx_done outside WAIT_DONE is ignored.
- A simultaneous owner valid and timeout terminal count: the byte is accepted, with no abort.
- Clients may drop valid before ready without penalty. The arbiter stores nothing until the accept cycle.
- Pointer wrap: NUM_REQ-1 → 0.
- Reset asserted in any state returns to SYNC immediately. Any lock is lost with no abort pulse.
- Counter width is clog2(LOCK_TIMEOUT+1), saturating.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (SYNC, IDLE, LOAD, WAIT_DONE, GAP, LOCKED)
  - the byte width constant 8
  - the default LOCK_TIMEOUT
- One natural sub-module: rr_pick, a combinational round-robin priority selector. Inputs are the request vector and pointer. Outputs are a one-hot grant and a found flag. It is reusable for other shared resources.

Test Plan:
- Single client 2 sends 0x41 with last=1 from IDLE → ready[2] in cycle N, avail with byte 0x41 at N+1, o_grant=0100. The next accept is no earlier than done+2.
- All four valid continuously, last=1, ptr=0 → grants in order 0,1,2,3,0. Each uart_tx byte matches its client's byte (0x10, 0x11, 0x12, 0x13).
- Client 1 sends frame 0xAA, 0xBB, 0xCC (last on 0xCC) while client 3 is valid → client 3 is not readied until after 0xCC's GAP. Line order is AA BB CC then client 3.
- Client 0 sends last=0, then stays idle with LOCK_TIMEOUT=16 and client 2 valid → o_lock_abort pulses once 16 cycles after LOCKED entry. Client 2 is granted next.
- Reset pulsed during WAIT_DONE while uart_tx is active → all outputs 0. No avail pulse until i_tx_active falls, then normal arbitration resumes from ptr 0.
- Spurious i_tx_done in IDLE with no requests → no state change, no outputs.
